write_ptr_ctrl: RTL

WRITE_PTR_CTRL -- requirements
Module: write_ptr_ctrl

---
 rtl/fifo_pkg.sv | 38 +++
 rtl/gray2bin.sv | 27 ++
 rtl/write_ptr_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer blocks (write and read
// side). Holds the default pointer width, the default pointer type and the
// binary-to-Gray helper used by both pointer controllers.
//
// Contents
//   ptr_width_def  default address width (FIFO depth = 2**ptr_width_def)
//   gray_max_bits  widest pointer bin2gray can convert
//   ptr_t          pointer type for the default width (ptr_width_def+1 bits)
//   status_t       registered write-side status flags
//   bin2gray       binary to reflected-Gray conversion
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int unsigned ptr_width_def = 8;
   localparam int unsigned gray_max_bits = 32;

   // One extra MSB distinguishes full from empty when the addresses match.
   typedef logic [ptr_width_def:0] ptr_t;

   typedef struct packed {
      logic full;
      logic almost_full;
      logic wr_ack;
      logic overflow;
   } status_t;

   // Works on a zero-extended value: Gray bit i depends only on binary bits
   // i and i+1, so the low bits of the result are the Gray code of the
   // narrower pointer and callers simply slice off what they need.
   function automatic logic [gray_max_bits-1:0] bin2gray(
      input logic [gray_max_bits-1:0] bin
   );
      return (bin >> 1) ^ bin;
   endfunction

endpackage

// File: rtl/gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Purely combinational reflected-Gray to binary converter.
//
// Parameters
//   width  pointer width in bits
// Ports
//   gray   input  [width-1:0]  Gray-coded value
//   bin    output [width-1:0]  binary equivalent
// -----------------------------------------------------------------------------
module gray2bin #(
   parameter int unsigned width = 4
) (
   input  logic [width-1:0] gray,
   output logic [width-1:0] bin
);

   // Binary bit i is the XOR of all Gray bits from i upwards. Written as a
   // reduction per bit rather than a ripple so there is no self-dependence.
   always_comb begin
      bin = '0;
      for (int i = 0; i < int'(width); i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/write_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// write_ptr_ctrl
// Write-domain pointer controller for an asynchronous FIFO. Keeps the binary
// write address and its Gray copy, derives full / almost_full / level from the
// read pointer already synchronised into wrclk, acknowledges accepted writes
// and records writes attempted while full.
//
// Parameters
//   ptr_width   address width, FIFO depth = 2**ptr_width (must be >= 2)
//   af_margin   almost_full when free slots <= af_margin (1..2**ptr_width-1)
// Ports
//   wrclk        input                 write clock
//   wr_rst_n     input                 asynchronous active-low reset
//   wr_en        input                 write request
//   rptr_sync    input  [ptr_width:0]  Gray read pointer in wrclk domain
//   ovf_clr      input                 clears the sticky overflow flag
//   wraddr       output [ptr_width:0]  binary write pointer
//   wptr         output [ptr_width:0]  Gray write pointer
//   full         output                FIFO full (registered)
//   almost_full  output                free slots <= af_margin (registered)
//   wr_level     output [ptr_width:0]  occupancy estimate 0..2**ptr_width
//   wr_ack       output                pulse one cycle after an accepted write
//   overflow     output                sticky: write attempted while full
// -----------------------------------------------------------------------------
module write_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ptr_width = ptr_width_def,
   parameter int unsigned af_margin = 2
) (
   input  logic               wrclk,
   input  logic               wr_rst_n,
   input  logic               wr_en,
   input  logic [ptr_width:0] rptr_sync,
   input  logic               ovf_clr,
   output logic [ptr_width:0] wraddr,
   output logic [ptr_width:0] wptr,
   output logic               full,
   output logic               almost_full,
   output logic [ptr_width:0] wr_level,
   output logic               wr_ack,
   output logic               overflow
);

   localparam int unsigned ptr_bits = ptr_width + 1;

   // Depth and margin carry one bit more than a pointer so the free-slot
   // subtraction below cannot alias.
   localparam logic [ptr_bits:0] depth  = {2'b01, {ptr_width{1'b0}}};
   localparam logic [ptr_bits:0] margin = (ptr_bits + 1)'(af_margin);

   logic                     accept;
   logic [ptr_width:0]       waddr_next;
   logic [ptr_width:0]       wptr_next;
   logic [gray_max_bits-1:0] gray_wide;
   logic [ptr_width:0]       rptr_full_cmp;
   logic [ptr_width:0]       rbin;
   logic [ptr_width:0]       level_next;
   logic [ptr_bits:0]        free_next;
   status_t                  status_q;
   status_t                  status_d;
   logic                     unused_gray_hi;

   // ---------------------------------------------------------------------------
   // Read pointer back to binary for the level calculation
   // ---------------------------------------------------------------------------
   gray2bin #(
      .width(ptr_bits)
   ) u_rptr_gray2bin (
      .gray(rptr_sync),
      .bin (rbin)
   );

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // Accept is qualified by the registered full, never a combinational one.
      accept     = wr_en & ~status_q.full;
      waddr_next = wraddr + ptr_bits'(accept);

      gray_wide  = bin2gray(gray_max_bits'(waddr_next));
      wptr_next  = gray_wide[ptr_width:0];

      // Full when the writer is exactly one lap ahead: in Gray code that is
      // the read pointer with its two top bits inverted.
      rptr_full_cmp = {~rptr_sync[ptr_width:ptr_width-1], rptr_sync[ptr_width-2:0]};

      level_next = waddr_next - rbin;
      free_next  = depth - {1'b0, level_next};

      status_d             = '0;
      status_d.full        = (wptr_next == rptr_full_cmp);
      status_d.almost_full = (free_next <= margin);
      status_d.wr_ack      = accept;
      // A new overflow attempt wins over a simultaneous clear.
      status_d.overflow    = (wr_en & status_q.full) | (status_q.overflow & ~ovf_clr);
   end

   // Only the low ptr_bits of the wide Gray result are meaningful here.
   assign unused_gray_hi = ^gray_wide;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   always_ff @(posedge wrclk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         wraddr   <= '0;
         wptr     <= '0;
         wr_level <= '0;
         status_q <= '0;
      end else begin
         wraddr   <= waddr_next;
         wptr     <= wptr_next;
         wr_level <= level_next;
         status_q <= status_d;
      end
   end

   assign full        = status_q.full;
   assign almost_full = status_q.almost_full;
   assign wr_ack      = status_q.wr_ack;
   assign overflow    = status_q.overflow;

endmodule
